mode_switch_sequencer: RTL and testbench

MODE_SWITCH_SEQUENCER -- requirements
Module: mode_switch_sequencer

---
 rtl/mode_switch_sequencer_pkg.sv | 22 ++
 rtl/mode_switch_sequencer_flag_stack.sv | 54 +++++
 rtl/mode_switch_sequencer.sv | 157 +++++++++++++++
 tb/tb_mode_switch_sequencer.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/mode_switch_sequencer_pkg.sv
// Shared types for the mode-switch sequencer: FSM state encoding and the
// flag-register update-mode selector values.
package mode_switch_sequencer_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        SAVE    = 3'd1,
        POP     = 3'd2,
        RESTORE = 3'd3,
        TOGGLE  = 3'd4,
        DONE    = 3'd5,
        FAULT   = 3'd6
    } state_t;

    localparam logic [3:0] UPD_NONE  = 4'd0;
    localparam logic [3:0] UPD_SHIFT = 4'd1;
    localparam logic [3:0] UPD_ADD   = 4'd2;
    localparam logic [3:0] UPD_MOV   = 4'd3;
    localparam logic [3:0] UPD_OVF   = 4'd4;
    localparam logic [3:0] UPD_SWI   = 4'd5;

endpackage

// File: rtl/mode_switch_sequencer_flag_stack.sv
// Bounded LIFO of saved {N,Z,C,V} flag sets. Push on full and pop on empty
// are ignored so the pointer never wraps; dout always shows the top entry.
module flag_stack #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 4
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         din,
    output logic [WIDTH-1:0]         dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [CW-1:0]    r_count;
    logic [PW-1:0]    w_wr_idx;
    logic [PW-1:0]    w_top_idx;
    logic             w_do_push;
    logic             w_do_pop;

    assign full      = (r_count == CW'(DEPTH));
    assign empty     = (r_count == '0);
    assign count     = r_count;
    // At count==DEPTH the low bits wrap to 0, so top index lands on DEPTH-1.
    assign w_wr_idx  = r_count[PW-1:0];
    assign w_top_idx = w_wr_idx - PW'(1);
    assign w_do_push = push && !full;
    assign w_do_pop  = pop && !empty && !push;
    assign dout      = r_mem[w_top_idx];

    always_ff @(posedge clock) begin
        if (reset) begin
            r_count <= '0;
        end else if (w_do_push) begin
            r_count <= r_count + CW'(1);
        end else if (w_do_pop) begin
            r_count <= r_count - CW'(1);
        end
    end

    always_ff @(posedge clock) begin
        if (!reset && w_do_push) begin
            r_mem[w_wr_idx] <= din;
        end
    end

endmodule

// File: rtl/mode_switch_sequencer.sv
// Sequences software-interrupt entry (save flags, toggle mode) and return
// (pop flags, restore, toggle mode) onto the flag register's write port.
module mode_switch_sequencer
    import mode_switch_sequencer_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     swi_req,
    input  logic                     rti_req,
    input  logic                     stall,
    input  logic [4:0]               flags_in,
    output logic                     spec_enable,
    output logic [3:0]               update_mode,
    output logic                     restore_sel,
    output logic [3:0]               restore_flags,
    output logic                     busy,
    output logic                     ack,
    output logic                     fault,
    output logic [$clog2(DEPTH):0]   depth_used,
    output state_t                   dbg_state
);

    state_t     r_state;
    state_t     w_next_state;
    logic [3:0] r_restore_flags;
    logic       w_push;
    logic       w_pop;
    logic       w_spec;
    logic [3:0] w_mode;
    logic       w_rsel;
    logic       w_ack;
    logic       w_fault;
    logic       w_busy;
    logic [3:0] w_stack_dout;
    logic       w_full;
    logic       w_empty;
    logic       w_unused_mode_bit;

    // The M bit is toggled by the flag register itself and is not saved.
    assign w_unused_mode_bit = flags_in[0];

    flag_stack #(
        .DEPTH (DEPTH),
        .WIDTH (4)
    ) u_flag_stack (
        .clock (clock),
        .reset (reset),
        .push  (w_push),
        .pop   (w_pop),
        .din   (flags_in[4:1]),
        .dout  (w_stack_dout),
        .full  (w_full),
        .empty (w_empty),
        .count (depth_used)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state         <= IDLE;
            r_restore_flags <= '0;
        end else begin
            r_state <= w_next_state;
            if (w_pop) begin
                r_restore_flags <= w_stack_dout;
            end
        end
    end

    always_comb begin
        w_next_state = r_state;
        w_push       = 1'b0;
        w_pop        = 1'b0;
        w_spec       = 1'b0;
        w_mode       = UPD_NONE;
        w_rsel       = 1'b0;
        w_ack        = 1'b0;
        w_fault      = 1'b0;
        w_busy       = (r_state != IDLE);
        // Every action below is gated by !stall so a stall freezes the state.
        case (r_state)
            IDLE: begin
                if (!stall) begin
                    if (swi_req) begin
                        w_next_state = w_full ? FAULT : SAVE;
                    end else if (rti_req) begin
                        w_next_state = w_empty ? FAULT : POP;
                    end
                end
            end
            SAVE: begin
                if (!stall) begin
                    w_push       = 1'b1;
                    w_next_state = TOGGLE;
                end
            end
            POP: begin
                if (!stall) begin
                    w_pop        = 1'b1;
                    w_next_state = RESTORE;
                end
            end
            RESTORE: begin
                if (!stall) begin
                    w_spec       = 1'b1;
                    w_mode       = UPD_ADD;
                    w_rsel       = 1'b1;
                    w_next_state = TOGGLE;
                end
            end
            TOGGLE: begin
                if (!stall) begin
                    w_spec       = 1'b1;
                    w_mode       = UPD_SWI;
                    w_next_state = DONE;
                end
            end
            DONE: begin
                if (!stall) begin
                    w_ack        = 1'b1;
                    w_next_state = IDLE;
                end
            end
            FAULT: begin
                if (!stall) begin
                    w_fault      = 1'b1;
                    w_next_state = IDLE;
                end
            end
            default: begin
                w_next_state = IDLE;
            end
        endcase
        // Reset aborts on the same edge: no partial flag write, no stack change.
        if (reset) begin
            w_push  = 1'b0;
            w_pop   = 1'b0;
            w_spec  = 1'b0;
            w_mode  = UPD_NONE;
            w_rsel  = 1'b0;
            w_ack   = 1'b0;
            w_fault = 1'b0;
            w_busy  = 1'b0;
        end
    end

    assign spec_enable   = w_spec;
    assign update_mode   = w_mode;
    assign restore_sel   = w_rsel;
    assign restore_flags = r_restore_flags;
    assign busy          = w_busy;
    assign ack           = w_ack;
    assign fault         = w_fault;
    assign dbg_state     = r_state;

endmodule

// File: tb/tb_mode_switch_sequencer.sv
// Directed bench for mode_switch_sequencer: a per-cycle vector table for the
// main SWI/RTI flows plus hand sequences for overflow, stall and reset abort.
module tb_mode_switch_sequencer;
    import mode_switch_sequencer_pkg::*;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       swi_req = 1'b0;
    logic       rti_req = 1'b0;
    logic       stall = 1'b0;
    logic [4:0] flags_in = '0;
    logic       spec_enable;
    logic [3:0] update_mode;
    logic       restore_sel;
    logic [3:0] restore_flags;
    logic       busy;
    logic       ack;
    logic       fault;
    logic [2:0] depth_used;
    state_t     dbg_state;

    int n_checks = 0;
    int n_errors = 0;

    typedef struct {
        logic       swi;
        logic       rti;
        logic       stl;
        logic [4:0] flags;
        logic       spec;
        logic [3:0] mode;
        logic       rsel;
        logic [3:0] rflags;
        logic       busy;
        logic       ack;
        logic       fault;
        logic [2:0] depth;
    } vec_t;

    vec_t vecs[$];

    mode_switch_sequencer #(.DEPTH(4)) dut (
        .clock         (clock),
        .reset         (reset),
        .swi_req       (swi_req),
        .rti_req       (rti_req),
        .stall         (stall),
        .flags_in      (flags_in),
        .spec_enable   (spec_enable),
        .update_mode   (update_mode),
        .restore_sel   (restore_sel),
        .restore_flags (restore_flags),
        .busy          (busy),
        .ack           (ack),
        .fault         (fault),
        .depth_used    (depth_used),
        .dbg_state     (dbg_state)
    );

    always #5 clock = ~clock;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset();
        reset   = 1'b1;
        swi_req = 1'b0;
        rti_req = 1'b0;
        stall   = 1'b0;
        tick();
        tick();
        reset = 1'b0;
        #1;
    endtask

    function automatic vec_t mk(input logic swi, input logic rti, input logic stl,
                                input logic [4:0] flags, input logic spec,
                                input logic [3:0] mode, input logic rsel,
                                input logic [3:0] rflags, input logic bsy,
                                input logic ak, input logic flt, input logic [2:0] depth);
        vec_t v;
        v.swi = swi; v.rti = rti; v.stl = stl; v.flags = flags;
        v.spec = spec; v.mode = mode; v.rsel = rsel; v.rflags = rflags;
        v.busy = bsy; v.ack = ak; v.fault = flt; v.depth = depth;
        return v;
    endfunction

    task automatic do_swi(input logic [4:0] f, input int idx);
        bit done;
        done     = 1'b0;
        swi_req  = 1'b1;
        flags_in = f;
        for (int i = 0; i < 10 && !done; i++) begin
            tick();
            if (ack || fault) done = 1'b1;
        end
        chk($sformatf("swi%0d_ack", idx), {31'd0, ack}, 32'd1);
        swi_req = 1'b0;
        tick();
    endtask

    initial begin
        // Reset state
        tick();
        tick();
        reset = 1'b0;
        #1;
        chk("rst_spec", spec_enable, 0);
        chk("rst_mode", update_mode, 0);
        chk("rst_rsel", restore_sel, 0);
        chk("rst_rflags", restore_flags, 0);
        chk("rst_busy", busy, 0);
        chk("rst_ack", ack, 0);
        chk("rst_fault", fault, 0);
        chk("rst_depth", depth_used, 0);
        chk("rst_state", dbg_state, IDLE);

        // Per-cycle vectors: inputs applied, one clock edge, then outputs compared.
        //                  swi rti stl flags     spec mode rsel rfl  busy ack flt depth
        vecs.push_back(mk(1, 0, 0, 5'b10100, 0, 0, 0, 4'h0, 1, 0, 0, 0)); // SAVE
        vecs.push_back(mk(1, 0, 0, 5'b10100, 1, 5, 0, 4'h0, 1, 0, 0, 1)); // TOGGLE
        vecs.push_back(mk(1, 0, 0, 5'b10100, 0, 0, 0, 4'h0, 1, 1, 0, 1)); // DONE
        vecs.push_back(mk(0, 0, 0, 5'b10100, 0, 0, 0, 4'h0, 0, 0, 0, 1)); // IDLE
        vecs.push_back(mk(0, 1, 0, 5'b00000, 0, 0, 0, 4'h0, 1, 0, 0, 1)); // POP
        vecs.push_back(mk(0, 1, 0, 5'b00000, 1, 2, 1, 4'hA, 1, 0, 0, 0)); // RESTORE
        vecs.push_back(mk(0, 1, 0, 5'b00000, 1, 5, 0, 4'hA, 1, 0, 0, 0)); // TOGGLE
        vecs.push_back(mk(0, 1, 0, 5'b00000, 0, 0, 0, 4'hA, 1, 1, 0, 0)); // DONE
        vecs.push_back(mk(0, 0, 0, 5'b00000, 0, 0, 0, 4'hA, 0, 0, 0, 0)); // IDLE
        vecs.push_back(mk(1, 0, 0, 5'b01011, 0, 0, 0, 4'hA, 1, 0, 0, 0)); // SAVE 0101
        vecs.push_back(mk(1, 0, 0, 5'b01011, 1, 5, 0, 4'hA, 1, 0, 0, 1));
        vecs.push_back(mk(1, 0, 0, 5'b01011, 0, 0, 0, 4'hA, 1, 1, 0, 1));
        vecs.push_back(mk(0, 0, 0, 5'b01011, 0, 0, 0, 4'hA, 0, 0, 0, 1));
        vecs.push_back(mk(1, 1, 0, 5'b11110, 0, 0, 0, 4'hA, 1, 0, 0, 1)); // both: SAVE wins
        vecs.push_back(mk(1, 1, 0, 5'b11110, 1, 5, 0, 4'hA, 1, 0, 0, 2));
        vecs.push_back(mk(1, 1, 0, 5'b11110, 0, 0, 0, 4'hA, 1, 1, 0, 2));
        vecs.push_back(mk(0, 0, 0, 5'b11110, 0, 0, 0, 4'hA, 0, 0, 0, 2));
        vecs.push_back(mk(0, 1, 0, 5'b00000, 0, 0, 0, 4'hA, 1, 0, 0, 2)); // pop 1111
        vecs.push_back(mk(0, 1, 0, 5'b00000, 1, 2, 1, 4'hF, 1, 0, 0, 1));
        vecs.push_back(mk(0, 1, 0, 5'b00000, 1, 5, 0, 4'hF, 1, 0, 0, 1));
        vecs.push_back(mk(0, 1, 0, 5'b00000, 0, 0, 0, 4'hF, 1, 1, 0, 1));
        vecs.push_back(mk(0, 0, 0, 5'b00000, 0, 0, 0, 4'hF, 0, 0, 0, 1));
        vecs.push_back(mk(0, 1, 0, 5'b00000, 0, 0, 0, 4'hF, 1, 0, 0, 1)); // pop 0101
        vecs.push_back(mk(0, 1, 0, 5'b00000, 1, 2, 1, 4'h5, 1, 0, 0, 0));
        vecs.push_back(mk(0, 1, 0, 5'b00000, 1, 5, 0, 4'h5, 1, 0, 0, 0));
        vecs.push_back(mk(0, 1, 0, 5'b00000, 0, 0, 0, 4'h5, 1, 1, 0, 0));
        vecs.push_back(mk(0, 0, 0, 5'b00000, 0, 0, 0, 4'h5, 0, 0, 0, 0));
        vecs.push_back(mk(0, 1, 0, 5'b00000, 0, 0, 0, 4'h5, 1, 0, 1, 0)); // empty -> FAULT
        vecs.push_back(mk(0, 0, 0, 5'b00000, 0, 0, 0, 4'h5, 0, 0, 0, 0));
        vecs.push_back(mk(1, 0, 1, 5'b00000, 0, 0, 0, 4'h5, 0, 0, 0, 0)); // stalled IDLE
        vecs.push_back(mk(0, 0, 0, 5'b00000, 0, 0, 0, 4'h5, 0, 0, 0, 0));

        foreach (vecs[i]) begin
            swi_req  = vecs[i].swi;
            rti_req  = vecs[i].rti;
            stall    = vecs[i].stl;
            flags_in = vecs[i].flags;
            tick();
            chk($sformatf("row%0d_spec", i), spec_enable, vecs[i].spec);
            chk($sformatf("row%0d_mode", i), update_mode, vecs[i].mode);
            chk($sformatf("row%0d_rsel", i), restore_sel, vecs[i].rsel);
            chk($sformatf("row%0d_rflags", i), restore_flags, vecs[i].rflags);
            chk($sformatf("row%0d_busy", i), busy, vecs[i].busy);
            chk($sformatf("row%0d_ack", i), ack, vecs[i].ack);
            chk($sformatf("row%0d_fault", i), fault, vecs[i].fault);
            chk($sformatf("row%0d_depth", i), depth_used, vecs[i].depth);
        end

        // Overflow: four pushes fill the stack, the fifth faults.
        do_reset();
        for (int k = 0; k < 4; k++) do_swi(5'b00010 << k, k);
        chk("ovf_depth_full", depth_used, 4);
        swi_req = 1'b1;
        tick();
        chk("ovf_fault", fault, 1);
        chk("ovf_spec", spec_enable, 0);
        chk("ovf_depth", depth_used, 4);
        chk("ovf_state", dbg_state, FAULT);
        swi_req = 1'b0;
        tick();
        chk("ovf_fault_clr", fault, 0);
        chk("ovf_depth_after", depth_used, 4);
        chk("ovf_state_after", dbg_state, IDLE);

        // Stall in SAVE skips the push; stall in TOGGLE holds off the write.
        do_reset();
        flags_in = 5'b00110;
        swi_req  = 1'b1;
        tick();
        chk("stl_save_state", dbg_state, SAVE);
        stall = 1'b1;
        tick();
        chk("stl_save_hold", dbg_state, SAVE);
        chk("stl_save_depth", depth_used, 0);
        stall = 1'b0;
        tick();
        chk("stl_toggle_state", dbg_state, TOGGLE);
        chk("stl_push_depth", depth_used, 1);
        stall = 1'b1;
        #1;
        for (int c = 0; c < 3; c++) begin
            chk($sformatf("stl_cyc%0d_spec", c), spec_enable, 0);
            chk($sformatf("stl_cyc%0d_mode", c), update_mode, 0);
            chk($sformatf("stl_cyc%0d_state", c), dbg_state, TOGGLE);
            if (c < 2) tick();
        end
        stall = 1'b0;
        #1;
        chk("stl_release_spec", spec_enable, 1);
        chk("stl_release_mode", update_mode, UPD_SWI);
        tick();
        chk("stl_ack", ack, 1);
        chk("stl_ack_spec", spec_enable, 0);
        swi_req = 1'b0;
        tick();
        chk("stl_idle_ack", ack, 0);

        // Reset while in RESTORE aborts with no toggle write.
        rti_req = 1'b1;
        tick();
        tick();
        chk("rr_state", dbg_state, RESTORE);
        chk("rr_spec", spec_enable, 1);
        chk("rr_mode", update_mode, UPD_ADD);
        chk("rr_rflags", restore_flags, 4'h3);
        reset = 1'b1;
        #1;
        chk("rr_gate_spec", spec_enable, 0);
        tick();
        reset   = 1'b0;
        rti_req = 1'b0;
        #1;
        chk("rr_post_state", dbg_state, IDLE);
        chk("rr_post_depth", depth_used, 0);
        chk("rr_post_rflags", restore_flags, 0);
        chk("rr_post_busy", busy, 0);
        chk("rr_post_ack", ack, 0);
        chk("rr_post_fault", fault, 0);
        for (int c = 0; c < 3; c++) begin
            chk($sformatf("rr_quiet%0d_spec", c), spec_enable, 0);
            chk($sformatf("rr_quiet%0d_mode", c), update_mode, 0);
            tick();
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
